// File: rtl/hamming_512b_encoder_pkg.sv
// -----------------------------------------------------------------------------
// hamming_512b_encoder_pkg
// Shared types and constants for the 512-bit SECDED encoder and decoder.
//
// Codeword layout: codeword bit i holds Hamming position i+1 (positions 1..522).
// Check bits sit at the power-of-two positions. Data bits fill the remaining
// positions in ascending order, LSB first. Bit 522 holds the overall parity.
//
// The helper functions are only called with constant arguments, from
// localparams and generate loops, so they add no logic of their own.
// -----------------------------------------------------------------------------
package hamming_512b_encoder_pkg;

    localparam int HAMMING_512B_DATA_W  = 512;
    localparam int HAMMING_512B_CHECK_W = 10;
    localparam int HAMMING_512B_CODE_W  = 523;
    // Positioned vector: Hamming positions 1..522, without the overall parity bit.
    localparam int HAMMING_512B_POS_W   = HAMMING_512B_CODE_W - 1;

    typedef logic [HAMMING_512B_DATA_W-1:0] cache_line_data_t;
    typedef logic [HAMMING_512B_CODE_W-1:0] hamming_512b_t;

    // Selects the positions covered by check bit k: every position whose
    // binary index has bit k set.
    function automatic logic [HAMMING_512B_POS_W-1:0] check_mask(input int k);
        logic [HAMMING_512B_POS_W-1:0] m;
        m = '0;
        for (int i = 0; i < HAMMING_512B_POS_W; i++) begin
            m[i] = (((i + 1) >> k) & 1) == 1;
        end
        return m;
    endfunction

    // Codeword bit that holds data bit d.
    function automatic int data_bit_index(input int d);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= HAMMING_512B_POS_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == d) begin
                    res = p - 1;
                end
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_512b_encoder_parity.sv
// -----------------------------------------------------------------------------
// hamming_512b_parity
// Computes the 10 Hamming check bits from a positioned 522-bit vector. The
// decoder reuses this block for syndrome generation, which is why it takes the
// positioned vector rather than raw data.
//
// Ports:
//   i_positioned [521:0] - bit i is Hamming position i+1. The encoder passes
//                          zeros at the check positions; the decoder passes
//                          the received check bits there.
//   o_check      [9:0]   - o_check[k] is even parity over every position that
//                          has bit k set.
// -----------------------------------------------------------------------------
module hamming_512b_parity
    import hamming_512b_encoder_pkg::*;
(
    input  logic [HAMMING_512B_POS_W-1:0]   i_positioned,
    output logic [HAMMING_512B_CHECK_W-1:0] o_check
);

    for (genvar k = 0; k < HAMMING_512B_CHECK_W; k++) begin : g_check
        localparam logic [HAMMING_512B_POS_W-1:0] MASK = check_mask(k);
        assign o_check[k] = ^(i_positioned & MASK);
    end

endmodule

// File: rtl/hamming_512b_encoder.sv
// -----------------------------------------------------------------------------
// hamming_512b_encoder
// SECDED (extended Hamming) encoder for one 512-bit cache line. It produces a
// 523-bit codeword: 512 data bits, 10 Hamming check bits and one overall
// even-parity bit in bit 522.
//
// Ports:
//   clk          - clock; used only when the output register is built in
//   reset        - asynchronous reset, active-low (0 = asserted); used only
//                  when the output register is built in
//   word_to_code - data to encode (cache_line_data_t)
//   coded_word   - codeword (hamming_512b_t)
//
// Build option HAMMING_512B_ENCODER_OUTPUT_REG_EN:
//   undefined - purely combinational; clk and reset are ignored
//   defined   - coded_word is registered on the rising edge of clk (one cycle
//               of latency). reset low forces it to 0, which is a valid
//               codeword.
// -----------------------------------------------------------------------------
module hamming_512b_encoder
    import hamming_512b_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  cache_line_data_t word_to_code,
    output hamming_512b_t    coded_word
);

    logic [HAMMING_512B_POS_W-1:0]   w_positioned;
    logic [HAMMING_512B_CHECK_W-1:0] w_check;
    hamming_512b_t                   w_code;

    // Data scatter. The mapping is fixed, so each data bit is plain wiring.
    for (genvar d = 0; d < HAMMING_512B_DATA_W; d++) begin : g_scatter
        localparam int CW_BIT = data_bit_index(d);
        assign w_positioned[CW_BIT] = word_to_code[d];
        assign w_code[CW_BIT]       = word_to_code[d];
    end

    // The parity block sees zeros at the check positions. The codeword carries
    // the computed check bits there instead.
    for (genvar k = 0; k < HAMMING_512B_CHECK_W; k++) begin : g_check_ins
        localparam int CB_BIT = (1 << k) - 1;
        assign w_positioned[CB_BIT] = 1'b0;
        assign w_code[CB_BIT]       = w_check[k];
    end

    hamming_512b_parity u_parity (
        .i_positioned (w_positioned),
        .o_check      (w_check)
    );

    assign w_code[HAMMING_512B_CODE_W-1] = ^w_code[HAMMING_512B_POS_W-1:0];

`ifdef HAMMING_512B_ENCODER_OUTPUT_REG_EN
    hamming_512b_t r_coded_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_coded_word <= '0;
        end else begin
            r_coded_word <= w_code;
        end
    end

    assign coded_word = r_coded_word;
`else
    // clk and reset are kept on the port list so that both builds have the
    // same interface; in this build they drive nothing.
    logic w_unused_clk_reset;
    assign w_unused_clk_reset = clk ^ reset;

    assign coded_word = w_code;
`endif

endmodule

// File: tb/tb_hamming_512b_encoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_512b_encoder
// Self-checking bench for hamming_512b_encoder. The bench works with either
// build; define HAMMING_512B_ENCODER_OUTPUT_REG_EN to get the registered one.
// -----------------------------------------------------------------------------
module tb_hamming_512b_encoder;
    import hamming_512b_encoder_pkg::*;

    logic             clk;
    logic             reset;
    cache_line_data_t word_to_code;
    hamming_512b_t    coded_word;

    int n_cmp  = 0;
    int n_fail = 0;

    hamming_512b_t sb_q[$];

    typedef struct {
        string            name;
        cache_line_data_t data;
        hamming_512b_t    exp;
    } vec_t;

    vec_t tbl[12];

    hamming_512b_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .word_to_code (word_to_code),
        .coded_word   (coded_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference encoder. The syndrome is built by XORing the positions of the
    // set data bits, which gives the check bits directly.
    function automatic hamming_512b_t ref_encode(input cache_line_data_t d);
        hamming_512b_t cw;
        logic [9:0]    syn;
        int            j;
        cw  = '0;
        syn = '0;
        j   = 0;
        for (int p = 1; p <= 522; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                if (d[j]) syn = syn ^ p[9:0];
                j++;
            end
        end
        for (int k = 0; k < 10; k++) cw[(1 << k) - 1] = syn[k];
        cw[522] = ^cw[521:0];
        return cw;
    endfunction

    function automatic logic [9:0] syndrome_of(input hamming_512b_t cw);
        logic [9:0] syn;
        syn = '0;
        for (int i = 0; i < 522; i++) begin
            int p;
            p = i + 1;
            if (cw[i]) syn = syn ^ p[9:0];
        end
        return syn;
    endfunction

    function automatic cache_line_data_t extract_data(input hamming_512b_t cw);
        cache_line_data_t d;
        int               j;
        d = '0;
        j = 0;
        for (int p = 1; p <= 522; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = cw[p-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic hamming_512b_t mk(input logic top, input logic [31:0] low);
        hamming_512b_t r;
        r        = '0;
        r[31:0]  = low;
        r[522]   = top;
        return r;
    endfunction

    task automatic check(input string nm, input hamming_512b_t act, input hamming_512b_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one word, pushes its expected codeword and compares it at the
    // point where the DUT presents it.
    task automatic apply(input string nm, input cache_line_data_t d, input hamming_512b_t exp);
        hamming_512b_t e;
        word_to_code = d;
        sb_q.push_back(exp);
`ifdef HAMMING_512B_ENCODER_OUTPUT_REG_EN
        @(posedge clk);
`endif
        #1;
        e = sb_q.pop_front();
        check(nm, coded_word, e);
    endtask

    initial begin
        cache_line_data_t d;
        hamming_512b_t    e508;
        hamming_512b_t    got;

        e508 = '0;
        e508[522] = 1'b1;
        e508[518] = 1'b1;
        e508[511] = 1'b1;
        e508[3]   = 1'b1;
        e508[1]   = 1'b1;
        e508[0]   = 1'b1;

        tbl[0]  = '{"zero",   512'h0,      mk(1'b0, 32'h0)};
        tbl[1]  = '{"d_1",    512'h1,      mk(1'b1, 32'h007)};
        tbl[2]  = '{"d_2",    512'h2,      mk(1'b1, 32'h019)};
        tbl[3]  = '{"d_4",    512'h4,      mk(1'b1, 32'h02A)};
        tbl[4]  = '{"d_8",    512'h8,      mk(1'b0, 32'h04B)};
        tbl[5]  = '{"d_3",    512'h3,      mk(1'b0, 32'h01E)};
        tbl[6]  = '{"d_7",    512'h7,      mk(1'b1, 32'h034)};
        tbl[7]  = '{"d_f",    512'hF,      mk(1'b1, 32'h07F)};
        tbl[8]  = '{"d_aaa",  512'hAAA,    mk(1'b0, 32'h1AAD3)};
        tbl[9]  = '{"d_aaaa", 512'hAAAA,   mk(1'b0, 32'h15AAD9)};
        tbl[10] = '{"d_b508", 512'h0,      e508};
        tbl[10].data[508] = 1'b1;
        tbl[11] = '{"zero_again", 512'h0,  mk(1'b0, 32'h0)};

        reset        = 1'b0;
        word_to_code = '0;
        #1;
        check("reset_state", coded_word, '0);

`ifdef HAMMING_512B_ENCODER_OUTPUT_REG_EN
        // The register must stay at 0 while reset is held, even across edges
        // and with a non-zero input.
        word_to_code = 512'h1;
        @(posedge clk);
        #1;
        check("reset_hold", coded_word, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_no_edge", coded_word, '0);
        @(posedge clk);
        #1;
        check("first_edge_d1", coded_word, mk(1'b1, 32'h007));
`else
        // In the combinational build, holding reset low must not affect the output.
        word_to_code = 512'h1;
        #1;
        check("reset_ignored", coded_word, mk(1'b1, 32'h007));
        reset = 1'b1;
`endif

        foreach (tbl[i]) apply(tbl[i].name, tbl[i].data, tbl[i].exp);

        for (int n = 0; n < 24; n++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            if (n == 0) d = '1;
            apply("rand_model", d, ref_encode(d));
            got = coded_word;
            check("rand_parity", {522'b0, ^got}, '0);
            check("rand_syndrome", {513'b0, syndrome_of(got)}, '0);
            check("rand_extract", {11'b0, extract_data(got)}, {11'b0, d});
        end

`ifdef HAMMING_512B_ENCODER_OUTPUT_REG_EN
        // Reset asserted between edges clears the output at once and discards
        // the word that was in flight.
        word_to_code = 512'hF;
        @(posedge clk);
        #1;
        check("pre_reset_f", coded_word, mk(1'b1, 32'h07F));
        word_to_code = 512'h3;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", coded_word, '0);
        @(posedge clk);
        #1;
        check("reset_discard", coded_word, '0);
        @(negedge clk);
        reset = 1'b1;
        word_to_code = 512'h1;
        @(posedge clk);
        #1;
        check("post_release_d1", coded_word, mk(1'b1, 32'h007));
`endif

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
